fifo_sync_mc: RTL and testbench
===============================

Name: fifo_sync_mc

Overview:
- Single-clock, multi-channel FIFO: CHANNELS independent logical queues share one RAM, partitioned as {channel, pointer}.
- One push port and one pop port; each port carries a channel select every cycle.
- Per-channel full/empty, almost flags and counts are exposed as packed vectors, with per-channel flush and overflow/underflow error pulses.
- Parametrised successor to the dual-clock FIFO, used where several streams share one clock domain.

Parameters:
- DATA_WIDTH, 8: word width.
- ADDR_WIDTH, 4: per-channel depth is 2^ADDR_WIDTH.
- CHANNELS, 4: number of logical queues, >=1, need not be a power of 2.
- CH_WIDTH, 2: channel select width; must satisfy 2^CH_WIDTH >= CHANNELS.
- LEAD_ALMOST_FULL, 3: full_a asserts when count >= 2^ADDR_WIDTH - LEAD_ALMOST_FULL.
- LEAD_ALMOST_EMPTY, 1: empty_a asserts when count <= LEAD_ALMOST_EMPTY.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  CHANNELS  per-channel synchronous clear.
- push  in  1  write request.
- push_ch  in  CH_WIDTH  target channel.
- push_data  in  DATA_WIDTH  write word.
- push_full  out  CHANNELS  per-channel full.
- push_full_a  out  CHANNELS  per-channel almost full.
- pop  in  1  read request.
- pop_ch  in  CH_WIDTH  source channel.
- pop_data  out  DATA_WIDTH  read word.
- pop_valid  out  1  pop_data valid.
- pop_empty  out  CHANNELS  per-channel empty.
- pop_empty_a  out  CHANNELS  per-channel almost empty.
- count  out  CHANNELS*(ADDR_WIDTH+1)  occupancy; channel c at bits [c*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].
- overflow  out  1  rejected push pulse.
- underflow  out  1  rejected pop pulse.

Behaviour:
- Reset (rst_n low, async):
  - all pointers 0, all counts 0;
  - pop_empty all 1s, pop_empty_a all 1s, push_full 0, push_full_a 0;
  - pop_valid 0, pop_data 0, overflow 0, underflow 0.
  - RAM contents are not reset.
- Pointers: per-channel wr/rd pointers, ADDR_WIDTH+1 bits, wrap modulo 2^(ADDR_WIDTH+1). count = wr - rd.
- Push is accepted iff push=1, push_ch < CHANNELS, the channel is not full and not flushed this cycle.
  - Accepted: RAM[{push_ch, wr[ADDR_WIDTH-1:0]}] <= push_data; wr++.
- Pop is accepted iff pop=1, pop_ch < CHANNELS, the channel is not empty and not flushed this cycle.
  - Accepted: rd++; pop_data registered from RAM next cycle with pop_valid=1 for exactly one cycle.
  - Read latency is 1 cycle; pop_data holds its last value when pop_valid=0.
- No bypass:
  - pop on an empty channel is rejected even if the same channel is pushed in the same cycle;
  - push on a full channel is rejected even if the same channel is popped in the same cycle.
- Push and pop on the same non-empty, non-full channel in one cycle: both accepted, count unchanged.
- Push and pop on different channels in one cycle: independent.
- Flush (flush[c]=1):
  - next cycle wr[c]=rd[c]=0, count 0, flags as after reset;
  - flush overrides push/pop to channel c in that cycle; those requests are dropped silently, no error pulse.
- Errors:
  - overflow=1 one cycle after a push rejected for full or for an out-of-range channel;
  - underflow=1 likewise for a rejected pop (empty or out-of-range channel);
  - both are single-cycle pulses, not sticky.
- Flags and counts are registered and reflect state after the current edge; no combinational path from push/pop to outputs.

Test Plan:
1. Reset, then push ch2 data 0x11,0x22,0x33, then pop ch2 x3 -> pop_data 0x11,0x22,0x33 each one cycle after its pop, pop_valid high 3 cycles; count[ch2] 1,2,3 then back to 0; pop_empty[2] returns to 1.
2. Push 16 words to ch0 -> push_full_a[0] asserts at count 13, push_full[0] at 16; 17th push -> overflow pulse, count stays 16; ch1-3 counts remain 0.
3. Interleave pushes to ch1 (0xA0..) and ch3 (0xB0..), then pop ch3 then ch1 -> each channel returns its own data in order, no cross-talk.
4. Pop empty ch1 with a simultaneous push to ch1 -> underflow pulse, count[1]=1 next cycle; then pop ch1 -> returns the pushed word.
5. Fill ch0 with 5 words, assert flush[0] together with push ch0 -> count[0]=0, pop_empty[0]=1, no overflow; the next push/pop works from pointer 0.
6. Push 40 words through ch2 while popping continuously at count 8 -> pointer wrap is correct, data order preserved, count holds 8; assert rst_n low mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_sync_mc_if.sv
// fifo_sync_mc_if: push/pop/flush bundle for the multi-channel FIFO.
//   master : drives flush, push, push_ch, push_data, pop, pop_ch; sees flags/data/errors
//   slave  : the FIFO side (inverse directions)
interface fifo_sync_mc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CHANNELS   = 4,
  parameter int CH_WIDTH   = 2
);
  logic [CHANNELS-1:0]                  flush;
  logic                                 push;
  logic [CH_WIDTH-1:0]                  push_ch;
  logic [DATA_WIDTH-1:0]                push_data;
  logic [CHANNELS-1:0]                  push_full;
  logic [CHANNELS-1:0]                  push_full_a;
  logic                                 pop;
  logic [CH_WIDTH-1:0]                  pop_ch;
  logic [DATA_WIDTH-1:0]                pop_data;
  logic                                 pop_valid;
  logic [CHANNELS-1:0]                  pop_empty;
  logic [CHANNELS-1:0]                  pop_empty_a;
  logic [CHANNELS*(ADDR_WIDTH+1)-1:0]   count;
  logic                                 overflow;
  logic                                 underflow;

  modport master (
    output flush, push, push_ch, push_data, pop, pop_ch,
    input  push_full, push_full_a, pop_data, pop_valid, pop_empty, pop_empty_a,
           count, overflow, underflow
  );

  modport slave (
    input  flush, push, push_ch, push_data, pop, pop_ch,
    output push_full, push_full_a, pop_data, pop_valid, pop_empty, pop_empty_a,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_mc.sv
// fifo_sync_mc: single-clock FIFO holding CHANNELS independent queues in one
// RAM addressed as {channel, pointer}.
//   clk   : clock, everything on posedge
//   rst_n : asynchronous active-low reset (RAM contents are not cleared)
//   bus   : fifo_sync_mc_if.slave -- push/pop requests with channel select,
//           per-channel flush, per-channel flags/counts, read data, error pulses
module fifo_sync_mc #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 4,
  parameter int CHANNELS          = 4,
  parameter int CH_WIDTH          = 2,
  parameter int LEAD_ALMOST_FULL  = 3,
  parameter int LEAD_ALMOST_EMPTY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_sync_mc_if.slave  bus
);
  localparam int PW        = ADDR_WIDTH + 1;
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int RAM_WORDS = 1 << (CH_WIDTH + ADDR_WIDTH);
  localparam logic [CH_WIDTH:0] NCH      = (CH_WIDTH+1)'(CHANNELS);
  localparam logic [PW-1:0]     FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0]     AF_CNT   = PW'(DEPTH - LEAD_ALMOST_FULL);
  localparam logic [PW-1:0]     AE_CNT   = PW'(LEAD_ALMOST_EMPTY);

  logic [PW-1:0]         wr_q [CHANNELS];
  logic [PW-1:0]         wr_d [CHANNELS];
  logic [PW-1:0]         rd_q [CHANNELS];
  logic [PW-1:0]         rd_d [CHANNELS];
  logic [PW-1:0]         cnt  [CHANNELS];
  logic [DATA_WIDTH-1:0] mem  [RAM_WORDS];

  logic [CHANNELS-1:0]   full, full_a, empty, empty_a;
  logic [CHANNELS-1:0]   push_acc, pop_acc;
  logic                  push_rng, pop_rng, push_blk, pop_blk;
  logic [ADDR_WIDTH-1:0] wr_lo, rd_lo;

  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  // Flags come only from the pointer registers, so they reflect the state
  // after the last edge and have no path from this cycle's requests.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt[c]     = wr_q[c] - rd_q[c];
      full[c]    = (cnt[c] == FULL_CNT);
      full_a[c]  = (cnt[c] >= AF_CNT);
      empty[c]   = (cnt[c] == '0);
      empty_a[c] = (cnt[c] <= AE_CNT);
    end
  end

  // Request decode. Selecting by loop keeps out-of-range channels from ever
  // indexing the per-channel arrays. A flushed channel swallows its requests
  // without raising an error; full/empty use pre-edge state (no bypass).
  always_comb begin
    push_rng = ({1'b0, bus.push_ch} < NCH);
    pop_rng  = ({1'b0, bus.pop_ch} < NCH);
    push_acc = '0;
    pop_acc  = '0;
    push_blk = 1'b0;
    pop_blk  = 1'b0;
    wr_lo    = '0;
    rd_lo    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.push_ch == CH_WIDTH'(c)) begin
        wr_lo = wr_q[c][ADDR_WIDTH-1:0];
        if (bus.push && !bus.flush[c]) begin
          if (full[c]) push_blk = 1'b1;
          else         push_acc[c] = 1'b1;
        end
      end
      if (bus.pop_ch == CH_WIDTH'(c)) begin
        rd_lo = rd_q[c][ADDR_WIDTH-1:0];
        if (bus.pop && !bus.flush[c]) begin
          if (empty[c]) pop_blk = 1'b1;
          else          pop_acc[c] = 1'b1;
        end
      end
    end
    overflow_d  = bus.push && (!push_rng || push_blk);
    underflow_d = bus.pop  && (!pop_rng  || pop_blk);
    pop_valid_d = |pop_acc;
    pop_data_d  = (|pop_acc) ? mem[{bus.pop_ch, rd_lo}] : pop_data_q;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_d[c] = bus.flush[c] ? '0 : wr_q[c] + PW'(push_acc[c]);
      rd_d[c] = bus.flush[c] ? '0 : rd_q[c] + PW'(pop_acc[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_q[c] <= '0;
        rd_q[c] <= '0;
      end
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_q[c] <= wr_d[c];
        rd_q[c] <= rd_d[c];
      end
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Write and read never hit the same word: a push needs the channel not
  // full, so wr and rd low bits differ whenever both are accepted.
  always_ff @(posedge clk) begin
    if (|push_acc) mem[{bus.push_ch, wr_lo}] <= bus.push_data;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
    assign bus.count[g*PW +: PW] = cnt[g];
  end

  assign bus.push_full   = full;
  assign bus.push_full_a = full_a;
  assign bus.pop_empty   = empty;
  assign bus.pop_empty_a = empty_a;
  assign bus.pop_data    = pop_data_q;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_fifo_sync_mc.sv
module tb_fifo_sync_mc;
  localparam int DW = 8, AW = 4, NC = 4, CW = 2, LAF = 3, LAE = 1;
  localparam int PW = AW + 1, DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(NC), .CH_WIDTH(CW)) bus ();

  fifo_sync_mc #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(NC), .CH_WIDTH(CW),
    .LEAD_ALMOST_FULL(LAF), .LEAD_ALMOST_EMPTY(LAE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, updated on the same edges.
  logic [7:0] mq [NC][$];
  logic [7:0] m_data  = '0;
  logic       m_valid = 1'b0;
  logic       m_ovf   = 1'b0;
  logic       m_udf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int sz [NC];
    int pc, qc;
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      for (int c = 0; c < NC; c++) sz[c] = mq[c].size();
      pc = int'(bus.push_ch);
      qc = int'(bus.pop_ch);
      m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0;
      if (bus.pop) begin
        if (qc >= NC) m_udf = 1'b1;
        else if (!bus.flush[qc]) begin
          if (sz[qc] == 0) m_udf = 1'b1;
          else begin
            m_data  = mq[qc].pop_front();
            m_valid = 1'b1;
          end
        end
      end
      if (bus.push) begin
        if (pc >= NC) m_ovf = 1'b1;
        else if (!bus.flush[pc]) begin
          if (sz[pc] == DEPTH) m_ovf = 1'b1;
          else mq[pc].push_back(bus.push_data);
        end
      end
      for (int c = 0; c < NC; c++) if (bus.flush[c]) mq[c].delete();
    end
  end

  always @(negedge clk) begin : compare
    logic [NC*PW-1:0] ec;
    logic [NC-1:0] ef, efa, ee, eea;
    int n;
    for (int c = 0; c < NC; c++) begin
      n = mq[c].size();
      ec[c*PW +: PW] = PW'(n);
      ef[c]  = (n == DEPTH);
      efa[c] = (n >= DEPTH - LAF);
      ee[c]  = (n == 0);
      eea[c] = (n <= LAE);
    end
    chk("count",       bus.count,       ec);
    chk("push_full",   bus.push_full,   ef);
    chk("push_full_a", bus.push_full_a, efa);
    chk("pop_empty",   bus.pop_empty,   ee);
    chk("pop_empty_a", bus.pop_empty_a, eea);
    chk("pop_valid",   bus.pop_valid,   m_valid);
    chk("pop_data",    bus.pop_data,    m_data);
    chk("overflow",    bus.overflow,    m_ovf);
    chk("underflow",   bus.underflow,   m_udf);
  end

  function automatic logic [PW-1:0] cnt_of(input int c);
    return bus.count[c*PW +: PW];
  endfunction

  task automatic cyc(input bit ps, input int pc, input logic [7:0] pd,
                     input bit pp, input int qc, input logic [NC-1:0] fl);
    bus.push = ps; bus.push_ch = CW'(pc); bus.push_data = pd;
    bus.pop = pp;  bus.pop_ch = CW'(qc);  bus.flush = fl;
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = '0;
  endtask

  initial begin
    bus.push = 1'b0; bus.push_ch = '0; bus.push_data = '0;
    bus.pop = 1'b0;  bus.pop_ch = '0;  bus.flush = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",     bus.count, 0);
    chk("rst_empty",     bus.pop_empty, 4'hF);
    chk("rst_empty_a",   bus.pop_empty_a, 4'hF);
    chk("rst_full",      bus.push_full, 0);
    chk("rst_pop_valid", bus.pop_valid, 0);
    chk("rst_pop_data",  bus.pop_data, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);

    // 1: three words through ch2
    cyc(1, 2, 8'h11, 0, 0, 0); chk("t1_cnt1", cnt_of(2), 1);
    cyc(1, 2, 8'h22, 0, 0, 0); chk("t1_cnt2", cnt_of(2), 2);
    cyc(1, 2, 8'h33, 0, 0, 0); chk("t1_cnt3", cnt_of(2), 3);
    cyc(0, 0, 0, 1, 2, 0); chk("t1_d0", bus.pop_data, 8'h11); chk("t1_v0", bus.pop_valid, 1);
    cyc(0, 0, 0, 1, 2, 0); chk("t1_d1", bus.pop_data, 8'h22);
    cyc(0, 0, 0, 1, 2, 0); chk("t1_d2", bus.pop_data, 8'h33);
    chk("t1_empty2", bus.pop_empty[2], 1);
    cyc(0, 0, 0, 0, 0, 0); chk("t1_hold", bus.pop_data, 8'h33); chk("t1_vlow", bus.pop_valid, 0);

    // 2: fill ch0 to full, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 8'(i), 0, 0, 0);
      chk("t2_full_a", bus.push_full_a[0], (i + 1 >= 13));
      chk("t2_full",   bus.push_full[0],   (i == DEPTH - 1));
    end
    cyc(1, 0, 8'hEE, 0, 0, 0);
    chk("t2_ovf", bus.overflow, 1);
    chk("t2_cnt16", cnt_of(0), 16);
    chk("t2_others", bus.count[NC*PW-1:PW], 0);
    cyc(0, 0, 0, 0, 0, 0); chk("t2_ovf_pulse", bus.overflow, 0);
    cyc(0, 0, 0, 0, 0, 4'b0001); chk("t2_flush", cnt_of(0), 0);

    // 3: interleaved ch1/ch3, read back ch3 first
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 8'hA0 + 8'(i), 0, 0, 0);
      cyc(1, 3, 8'hB0 + 8'(i), 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 3, 0); chk("t3_ch3", bus.pop_data, 8'hB0 + 8'(i));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 1, 0); chk("t3_ch1", bus.pop_data, 8'hA0 + 8'(i));
    end

    // 4: pop of empty ch1 with simultaneous push (no bypass)
    cyc(1, 1, 8'h5A, 1, 1, 0);
    chk("t4_udf", bus.underflow, 1);
    chk("t4_cnt", cnt_of(1), 1);
    cyc(0, 0, 0, 1, 1, 0);
    chk("t4_data", bus.pop_data, 8'h5A);
    chk("t4_udf_pulse", bus.underflow, 0);

    // 5: flush with concurrent push
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h60 + 8'(i), 0, 0, 0);
    cyc(1, 0, 8'h77, 0, 0, 4'b0001);
    chk("t5_cnt", cnt_of(0), 0);
    chk("t5_empty", bus.pop_empty[0], 1);
    chk("t5_no_ovf", bus.overflow, 0);
    cyc(1, 0, 8'h99, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0); chk("t5_data", bus.pop_data, 8'h99);

    // 6: streaming through ch2 with wrap, then reset mid-stream
    for (int i = 0; i < 40; i++) begin
      cyc(1, 2, 8'hC0 + 8'(i), (i >= 8), 2, 0);
      chk("t6_cnt", cnt_of(2), (i < 8) ? i + 1 : 8);
      if (i >= 8) chk("t6_data", bus.pop_data, 8'hC0 + 8'(i - 8));
    end
    bus.push = 1'b1; bus.push_ch = 2'd2; bus.pop = 1'b1; bus.pop_ch = 2'd2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", bus.count, 0);
    chk("t6_rst_empty", bus.pop_empty, 4'hF);
    chk("t6_rst_empty_a", bus.pop_empty_a, 4'hF);
    chk("t6_rst_full_a", bus.push_full_a, 0);
    chk("t6_rst_valid", bus.pop_valid, 0);
    chk("t6_rst_data", bus.pop_data, 0);
    repeat (2) @(posedge clk);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
